tdm_demux: RTL and testbench

TDM_DEMUX -- requirements
Module: tdm_demux

---
 rtl/tdm_demux_if.sv | 25 ++
 rtl/tdm_demux.sv | 81 ++++++++
 tb/tb_tdm_demux.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tdm_demux_if.sv
// TDM demultiplexer bus: serial sample input side and per-channel output side.
// The master drives the serial stream; the slave is the demultiplexer.
interface tdm_demux_if #(
    parameter int W   = 8,
    parameter int NCH = 4
);
    logic                 in_valid;
    logic                 in_sync;
    logic [W-1:0]         in_data;
    logic [NCH*W-1:0]     out_data;
    logic [NCH-1:0]       out_valid;
    logic                 frame_done;
    logic                 err;
    logic [7:0]           err_cnt;

    modport master (
        output in_valid, in_sync, in_data,
        input  out_data, out_valid, frame_done, err, err_cnt
    );

    modport slave (
        input  in_valid, in_sync, in_data,
        output out_data, out_valid, frame_done, err, err_cnt
    );
endinterface

// File: rtl/tdm_demux.sv
// Splits a serial TDM stream into NCH per-channel holding registers, tracking
// frame alignment from the sync marker and counting framing errors.
module tdm_demux #(
    parameter int W   = 8,
    parameter int NCH = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    tdm_demux_if.slave   bus
);
    localparam int SW = (NCH > 1) ? $clog2(NCH) : 1;

    typedef enum logic {
        HUNT = 1'b0,
        RUN  = 1'b1
    } state_e;

    state_e                  state_q;
    logic [SW-1:0]           slot_q;
    logic [NCH-1:0][W-1:0]   data_q;
    logic [NCH-1:0]          out_valid_q;
    logic                    frame_done_q;
    logic                    err_q;
    logic [7:0]              err_cnt_q;
    logic [7:0]              err_cnt_d;
    logic                    frm_err_d;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // A stray sample while hunting, or a sync arriving before the frame closed.
    always_comb begin
        frm_err_d = bus.in_valid &&
                    (((state_q == HUNT) && !bus.in_sync) ||
                     ((state_q == RUN)  &&  bus.in_sync));
        err_cnt_d = frm_err_d ? sat_inc(err_cnt_q) : err_cnt_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= HUNT;
            slot_q       <= '0;
            data_q       <= '0;
            out_valid_q  <= '0;
            frame_done_q <= 1'b0;
            err_q        <= 1'b0;
            err_cnt_q    <= '0;
        end else begin
            out_valid_q  <= '0;
            frame_done_q <= 1'b0;
            err_q        <= frm_err_d;
            err_cnt_q    <= err_cnt_d;
            if (bus.in_valid) begin
                // A sync always (re)starts a frame at channel 0, even mid-frame.
                if (bus.in_sync) begin
                    data_q[0]   <= bus.in_data;
                    out_valid_q <= NCH'(1);
                    slot_q      <= SW'(1);
                    state_q     <= RUN;
                end else if (state_q == RUN) begin
                    data_q[slot_q] <= bus.in_data;
                    out_valid_q    <= NCH'(1) << slot_q;
                    if (slot_q == SW'(NCH - 1)) begin
                        frame_done_q <= 1'b1;
                        slot_q       <= '0;
                        state_q      <= HUNT;
                    end else begin
                        slot_q <= slot_q + SW'(1);
                    end
                end
            end
        end
    end

    assign bus.out_data   = data_q;
    assign bus.out_valid  = out_valid_q;
    assign bus.frame_done = frame_done_q;
    assign bus.err        = err_q;
    assign bus.err_cnt    = err_cnt_q;
endmodule

// File: tb/tb_tdm_demux.sv
// Bench for tdm_demux: directed framing scenarios plus a randomized stream
// compared against a frame-level reference model.
module tb_tdm_demux;
    localparam int W   = 8;
    localparam int NCH = 4;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    tdm_demux_if #(.W(W), .NCH(NCH)) tif ();

    tdm_demux #(.W(W), .NCH(NCH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (tif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state: captured channels, whether a frame is open and
    // which slot comes next, plus the expected registered outputs.
    logic [W-1:0]     m_data [NCH];
    bit               m_open;
    int               m_next;
    int               m_cnt;
    logic [NCH-1:0]   exp_ov;
    logic             exp_fd;
    logic             exp_err;

    function automatic logic [NCH*W-1:0] m_packed();
        logic [NCH*W-1:0] r;
        for (int k = 0; k < NCH; k++) r[k*W +: W] = m_data[k];
        return r;
    endfunction

    task automatic model_clear();
        for (int k = 0; k < NCH; k++) m_data[k] = '0;
        m_open  = 0;
        m_next  = 0;
        m_cnt   = 0;
        exp_ov  = '0;
        exp_fd  = 1'b0;
        exp_err = 1'b0;
    endtask

    task automatic model_step(input bit v, input bit s, input logic [W-1:0] d);
        exp_ov  = '0;
        exp_fd  = 1'b0;
        exp_err = 1'b0;
        if (v) begin
            if (s) begin
                if (m_open) exp_err = 1'b1;
                m_data[0] = d;
                exp_ov[0] = 1'b1;
                m_open    = 1;
                m_next    = 1;
            end else if (!m_open) begin
                exp_err = 1'b1;
            end else begin
                m_data[m_next] = d;
                exp_ov[m_next] = 1'b1;
                if (m_next == NCH - 1) begin
                    exp_fd = 1'b1;
                    m_open = 0;
                    m_next = 0;
                end else begin
                    m_next++;
                end
            end
            if (exp_err && m_cnt < 255) m_cnt++;
        end
    endtask

    // Present one input cycle, let the DUT take the edge, then update the model.
    task automatic cyc(input bit v, input bit s, input logic [W-1:0] d);
        tif.in_valid = v;
        tif.in_sync  = s;
        tif.in_data  = d;
        @(posedge clk);
        #1;
        model_step(v, s, d);
    endtask

    task automatic do_reset();
        tif.in_valid = 1'b0;
        tif.in_sync  = 1'b0;
        tif.in_data  = '0;
        #2;
        rst_n = 1'b0;
        model_clear();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        tif.in_valid = 1'b0;
        tif.in_sync  = 1'b0;
        tif.in_data  = '0;
        rst_n = 1'b1;
        #2;
        rst_n = 1'b0;
        model_clear();
        #1;
        checks++; if (tif.out_data !== '0) begin errors++; $display("FAIL reset_out_data: got %h want 0", tif.out_data); end
        checks++; if (tif.out_valid !== '0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", tif.out_valid); end
        checks++; if (tif.frame_done !== 1'b0) begin errors++; $display("FAIL reset_frame_done: got %b want 0", tif.frame_done); end
        checks++; if (tif.err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", tif.err); end
        checks++; if (tif.err_cnt !== 8'd0) begin errors++; $display("FAIL reset_err_cnt: got %0d want 0", tif.err_cnt); end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_basic_frame();
        logic [W-1:0]   b [NCH];
        logic [NCH-1:0] want_ov;
        b[0] = 8'h11; b[1] = 8'h22; b[2] = 8'h33; b[3] = 8'h44;
        do_reset();
        for (int i = 0; i < NCH; i++) begin
            cyc(1'b1, i == 0, b[i]);
            want_ov = '0;
            want_ov[i] = 1'b1;
            checks++; if (tif.out_valid !== want_ov) begin errors++; $display("FAIL basic_out_valid[%0d]: got %b want %b", i, tif.out_valid, want_ov); end
            checks++; if (tif.frame_done !== (i == NCH - 1)) begin errors++; $display("FAIL basic_frame_done[%0d]: got %b want %b", i, tif.frame_done, i == NCH - 1); end
            checks++; if (tif.err !== 1'b0) begin errors++; $display("FAIL basic_err[%0d]: got %b want 0", i, tif.err); end
        end
        checks++; if (tif.out_data !== 32'h44332211) begin errors++; $display("FAIL basic_out_data: got %h want 44332211", tif.out_data); end
        cyc(1'b0, 1'b0, 8'h00);
        checks++; if (tif.frame_done !== 1'b0) begin errors++; $display("FAIL basic_fd_one_cycle: got %b want 0", tif.frame_done); end
    endtask

    task automatic test_hunt_error();
        do_reset();
        cyc(1'b1, 1'b0, 8'hAA);
        checks++; if (tif.err !== 1'b1) begin errors++; $display("FAIL hunt_err: got %b want 1", tif.err); end
        checks++; if (tif.out_valid !== '0) begin errors++; $display("FAIL hunt_dropped: got %b want 0", tif.out_valid); end
        checks++; if (tif.err_cnt !== 8'd1) begin errors++; $display("FAIL hunt_err_cnt: got %0d want 1", tif.err_cnt); end
        for (int i = 0; i < NCH; i++) begin
            cyc(1'b1, i == 0, 8'(i + 1));
            checks++; if (tif.err !== 1'b0) begin errors++; $display("FAIL hunt_frame_err[%0d]: got %b want 0", i, tif.err); end
        end
        checks++; if (tif.frame_done !== 1'b1) begin errors++; $display("FAIL hunt_frame_done: got %b want 1", tif.frame_done); end
        checks++; if (tif.out_data !== 32'h04030201) begin errors++; $display("FAIL hunt_out_data: got %h want 04030201", tif.out_data); end
        checks++; if (tif.err_cnt !== 8'd1) begin errors++; $display("FAIL hunt_err_cnt_final: got %0d want 1", tif.err_cnt); end
    endtask

    task automatic test_short_frame();
        logic [W-1:0] b [6];
        int n_err;
        int n_fd;
        b[0] = 8'h01; b[1] = 8'h02; b[2] = 8'h10; b[3] = 8'h20; b[4] = 8'h30; b[5] = 8'h40;
        n_err = 0;
        n_fd  = 0;
        do_reset();
        for (int i = 0; i < 6; i++) begin
            cyc(1'b1, (i == 0) || (i == 2), b[i]);
            if (tif.err === 1'b1) n_err++;
            if (tif.frame_done === 1'b1) n_fd++;
            if (i == 2) begin
                checks++; if (tif.err !== 1'b1) begin errors++; $display("FAIL short_err_on_sync: got %b want 1", tif.err); end
                checks++; if (tif.out_valid !== 4'b0001) begin errors++; $display("FAIL short_resync_valid: got %b want 0001", tif.out_valid); end
            end
        end
        checks++; if (n_err != 1) begin errors++; $display("FAIL short_err_pulses: got %0d want 1", n_err); end
        checks++; if (n_fd != 1) begin errors++; $display("FAIL short_frame_done_pulses: got %0d want 1", n_fd); end
        checks++; if (tif.out_data !== 32'h40302010) begin errors++; $display("FAIL short_out_data: got %h want 40302010", tif.out_data); end
        checks++; if (tif.err_cnt !== 8'd1) begin errors++; $display("FAIL short_err_cnt: got %0d want 1", tif.err_cnt); end
    endtask

    task automatic test_gaps();
        logic [W-1:0] b [NCH];
        b[0] = 8'h11; b[1] = 8'h22; b[2] = 8'h33; b[3] = 8'h44;
        do_reset();
        for (int i = 0; i < NCH; i++) begin
            cyc(1'b1, i == 0, b[i]);
            for (int g = 0; g < 3; g++) begin
                // Idle cycles carry junk sync/data that must be ignored.
                cyc(1'b0, 1'($urandom_range(0, 1)), 8'($urandom));
                checks++; if (tif.out_valid !== '0) begin errors++; $display("FAIL gap_out_valid[%0d.%0d]: got %b want 0", i, g, tif.out_valid); end
                checks++; if (tif.err !== 1'b0) begin errors++; $display("FAIL gap_err[%0d.%0d]: got %b want 0", i, g, tif.err); end
            end
        end
        checks++; if (tif.out_data !== 32'h44332211) begin errors++; $display("FAIL gap_out_data: got %h want 44332211", tif.out_data); end
        checks++; if (tif.err_cnt !== 8'd0) begin errors++; $display("FAIL gap_err_cnt: got %0d want 0", tif.err_cnt); end
    endtask

    task automatic test_reset_midframe();
        do_reset();
        cyc(1'b1, 1'b1, 8'h11);
        cyc(1'b1, 1'b0, 8'h22);
        tif.in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        model_clear();
        #1;
        checks++; if (tif.out_data !== '0) begin errors++; $display("FAIL midrst_out_data: got %h want 0", tif.out_data); end
        checks++; if (tif.out_valid !== '0) begin errors++; $display("FAIL midrst_out_valid: got %b want 0", tif.out_valid); end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc(1'b1, 1'b0, 8'h55);
        checks++; if (tif.err !== 1'b1) begin errors++; $display("FAIL midrst_err: got %b want 1", tif.err); end
        checks++; if (tif.err_cnt !== 8'd1) begin errors++; $display("FAIL midrst_err_cnt: got %0d want 1", tif.err_cnt); end
        checks++; if (tif.out_data !== '0) begin errors++; $display("FAIL midrst_dropped: got %h want 0", tif.out_data); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int f = 0; f < 3; f++) begin
            for (int i = 0; i < NCH; i++) begin
                cyc(1'b1, i == 0, 8'($urandom));
                checks++; if (tif.err !== 1'b0) begin errors++; $display("FAIL b2b_err[%0d.%0d]: got %b want 0", f, i, tif.err); end
                checks++; if (tif.out_valid !== exp_ov) begin errors++; $display("FAIL b2b_out_valid[%0d.%0d]: got %b want %b", f, i, tif.out_valid, exp_ov); end
                checks++; if (tif.frame_done !== exp_fd) begin errors++; $display("FAIL b2b_frame_done[%0d.%0d]: got %b want %b", f, i, tif.frame_done, exp_fd); end
            end
            checks++; if (tif.out_data !== m_packed()) begin errors++; $display("FAIL b2b_out_data[%0d]: got %h want %h", f, tif.out_data, m_packed()); end
        end
    endtask

    task automatic test_saturate();
        do_reset();
        for (int i = 1; i <= 300; i++) begin
            cyc(1'b1, 1'b0, 8'($urandom));
            if (i == 254) begin
                checks++; if (tif.err_cnt !== 8'd254) begin errors++; $display("FAIL sat_cnt_254: got %0d want 254", tif.err_cnt); end
            end
            if (i == 255) begin
                checks++; if (tif.err_cnt !== 8'd255) begin errors++; $display("FAIL sat_cnt_255: got %0d want 255", tif.err_cnt); end
            end
        end
        checks++; if (tif.err_cnt !== 8'd255) begin errors++; $display("FAIL sat_cnt_hold: got %0d want 255", tif.err_cnt); end
        checks++; if (tif.err !== 1'b1) begin errors++; $display("FAIL sat_err_pulse: got %b want 1", tif.err); end
        checks++; if (tif.err_cnt !== 8'(m_cnt)) begin errors++; $display("FAIL sat_cnt_model: got %0d want %0d", tif.err_cnt, m_cnt); end
    endtask

    task automatic test_random();
        bit v;
        bit s;
        do_reset();
        for (int n = 0; n < 2000; n++) begin
            v = ($urandom_range(0, 3) != 0);
            s = ($urandom_range(0, 4) == 0);
            cyc(v, s, 8'($urandom));
            checks++; if (tif.out_data !== m_packed()) begin errors++; $display("FAIL rand_out_data[%0d]: got %h want %h", n, tif.out_data, m_packed()); end
            checks++; if (tif.out_valid !== exp_ov) begin errors++; $display("FAIL rand_out_valid[%0d]: got %b want %b", n, tif.out_valid, exp_ov); end
            checks++; if ($countones(tif.out_valid) > 1) begin errors++; $display("FAIL rand_onehot[%0d]: got %b want at most one bit", n, tif.out_valid); end
            checks++; if (tif.frame_done !== exp_fd) begin errors++; $display("FAIL rand_frame_done[%0d]: got %b want %b", n, tif.frame_done, exp_fd); end
            checks++; if (tif.err !== exp_err) begin errors++; $display("FAIL rand_err[%0d]: got %b want %b", n, tif.err, exp_err); end
            checks++; if (tif.err_cnt !== 8'(m_cnt)) begin errors++; $display("FAIL rand_err_cnt[%0d]: got %0d want %0d", n, tif.err_cnt, m_cnt); end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b1;
        tif.in_valid = 1'b0;
        tif.in_sync  = 1'b0;
        tif.in_data  = '0;
        model_clear();
        test_reset();
        test_basic_frame();
        test_hunt_error();
        test_short_frame();
        test_gaps();
        test_reset_midframe();
        test_back_to_back();
        test_saturate();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
